// File: rtl/burst_receiver_if.sv
// ============================================================================
// Module      : burst_receiver_if
// Description : Pulse-train input and burst-report outputs of burst_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface burst_receiver_if #(
  parameter int CNT_W = 8
);
  logic             burstIn;
  logic [CNT_W-1:0] count;
  logic             countValid;
  logic             overflow;
  logic             busy;

  // Pulse source / report consumer side
  modport master (
    output burstIn,
    input  count,
    input  countValid,
    input  overflow,
    input  busy
  );

  // Receiver side
  modport slave (
    input  burstIn,
    output count,
    output countValid,
    output overflow,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/burst_receiver.sv
// ============================================================================
// Module      : burst_receiver
// Description : Counts rising edges of a pulse burst; reports after idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_receiver #(
  parameter int CNT_W       = 8,
  parameter int IDLE_CYCLES = 64,
  parameter int GAP_W       = 7
) (
  input  wire logic        clk,
  input  wire logic        reset,
  burst_receiver_if.slave  bus
);

  localparam logic [1:0]       C_IDLE     = 2'd0;
  localparam logic [1:0]       C_COUNT    = 2'd1;
  localparam logic [1:0]       C_DONE     = 2'd2;
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(IDLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic             r_s1;
  logic             r_s2;
  logic             r_prev;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_rise;

  assign w_rise = r_s2 & ~r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= C_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_prev      <= 1'b0;
      r_pulse_cnt <= '0;
      r_gap_cnt   <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_s1   <= bus.burstIn;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      case (r_state)
        // A rise in DONE starts the next burst immediately so no edge is lost
        C_IDLE, C_DONE: begin
          if (w_rise) begin
            r_state     <= C_COUNT;
            r_pulse_cnt <= CNT_W'(1);
            r_gap_cnt   <= '0;
            r_ovf       <= 1'b0;
          end else begin
            r_state <= C_IDLE;
          end
        end
        C_COUNT: begin
          if (w_rise) begin
            r_gap_cnt <= '0;
            if (&r_pulse_cnt) begin
              r_ovf <= 1'b1;
            end else begin
              r_pulse_cnt <= r_pulse_cnt + CNT_W'(1);
            end
          end else if (r_gap_cnt == C_GAP_LAST) begin
            r_state    <= C_DONE;
            r_count    <= r_pulse_cnt;
            r_overflow <= r_ovf;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.countValid = (r_state == C_DONE);
  assign bus.busy       = (r_state == C_COUNT);

endmodule

`default_nettype wire

// File: doc/burst_receiver.md
# burst_receiver

Receive-side counterpart of the `Burst` clock-burst generator. Samples a pulse train such as `burstClk` on the system clock and counts its rising edges. It declares the burst finished after a programmable idle gap, then reports the pulse count with a one-cycle valid strobe. It sits downstream of `Burst`, or of any pulse source, for measurement, self-check and display logic.

## Interface
- `CNT_W`, default 8: width of pulse counter and `count` output.
- `IDLE_CYCLES`, default 64: number of cycles without a rising edge that terminates a burst. Must be ≥ 2 and greater than the source pulse period.
- `GAP_W`, default 7: width of the gap counter. Must satisfy 2^GAP_W > IDLE_CYCLES.

Ports:
- `clk`  in  1  system clock. Single clock domain; every register updates on the rising edge of `clk`.
- `reset`  in  1  synchronous, active-high reset.
- `burstIn`  in  1  pulse train. Treated as asynchronous and passed through a 2-flop synchronizer.
- `count`  out  CNT_W  pulse count of the last completed burst. Held until the next completion.
- `countValid`  out  1  one-cycle strobe when `count`/`overflow` update.
- `overflow`  out  1  last completed burst exceeded 2^CNT_W−1 pulses.
- `busy`  out  1  burst in progress (state COUNT).

## Operation
- Input path:
  - `burstIn` → `s1` → `s2` → `prev`.
  - `rise = s2 & ~prev`.
  - Input held high produces exactly one `rise`.
  - A pulse must stay low for at least 1 clk to be seen again.
- Registers:
  - `state`: IDLE, COUNT, DONE.
  - `pulseCnt[CNT_W-1:0]`, `gapCnt[GAP_W-1:0]`, `ovf`.
  - Output registers `count`, `overflow`.
- IDLE:
  - `rise` → COUNT, with `pulseCnt`=1, `gapCnt`=0, `ovf`=0.
- COUNT:
  - On `rise`: `gapCnt`←0.
    - If `pulseCnt` = all ones: `ovf`←1 and `pulseCnt` saturates (no wrap).
    - Otherwise `pulseCnt`++.
  - No `rise` and `gapCnt` < IDLE_CYCLES−1: `gapCnt`++.
  - No `rise` and `gapCnt` = IDLE_CYCLES−1: → DONE, `count`←`pulseCnt`, `overflow`←`ovf`.
  - A `rise` always has priority over the timeout.
- DONE, one cycle:
  - `countValid`=1.
  - Then → IDLE.
  - If `rise` occurs in this cycle, go directly to COUNT with `pulseCnt`=1, `gapCnt`=0, `ovf`=0. That edge is not lost.
- Outputs:
  - `busy` = (state==COUNT).
  - `countValid` = (state==DONE).
  - Both are decoded from registered state, so they are glitch-free.
- Reset:
  - `state`=IDLE.
  - `s1`, `s2`, `prev`, `pulseCnt`, `gapCnt`, `ovf`, `count`, `overflow` all cleared.
  - Resulting outputs: `count`=0, `overflow`=0, `countValid`=0, `busy`=0.
  - Reset asserted mid-burst discards the burst; no `countValid` is produced.

## Timing
- `burstIn` first sampled high at edge n:
  - `s2` high after edge n+1.
  - `rise` high during cycle n+1→n+2.
  - `busy` rises after edge n+2.
- Input-to-`busy` latency: 2 clk edges.
- Last `rise` in cycle t, no further rises:
  - `gapCnt` runs 0..IDLE_CYCLES−1 over cycles t+1..t+IDLE_CYCLES.
  - `countValid` is high in cycle t+IDLE_CYCLES+1; `count` is valid in the same cycle.
  - `busy` falls in the same cycle.
- Gap boundary (rise-to-rise spacing):
  - ≤ IDLE_CYCLES: the bursts merge into one.
  - = IDLE_CYCLES+1: the second rise lands in DONE and starts a new burst with no idle cycle in between.
- Throughput: one edge per 2 clk minimum (high 1, low 1).

## Test plan
1. Reset held 5 cycles with `burstIn` toggling, then released with `burstIn`=0 → `count`=0, `overflow`=0, `countValid`=0, `busy`=0 throughout.
2. `Burst #(10)` drives `burstIn` (period 20 clk), 10 rising edges, then the source stops → exactly one `countValid`, 65 cycles after the last `rise`; `count`=10, `overflow`=0.
3. `burstIn` held high for 200 cycles, then low → single completion, `count`=1.
4. `CNT_W`=4, 20 edges at period 4 → `count`=15, `overflow`=1. The next 3-edge burst reports `count`=3, `overflow`=0.
5. Two edges spaced 64 cycles apart → one completion with `count`=2. Edges spaced 65 cycles apart → two `countValid` strobes each with `count`=1, the second following the first with no missed edge.
6. `reset` asserted for 1 cycle after 4 edges of a burst → no `countValid`, `count` stays 0, `busy`=0 the cycle after reset. A subsequent 3-edge burst reports `count`=3.
